// File: rtl/mvm_pkg.sv
// Shared types and sizing helpers for the matrix-vector multiply engine.
package mvm_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam int DEF_COLS = 8;

  function automatic int cnt_width(input int cols);
    return $clog2(cols + 1);
  endfunction

  function automatic int default_acc_width(input int data_width, input int cols);
    return 2 * data_width + $clog2(cols);
  endfunction

  localparam int CNT_W = cnt_width(DEF_COLS);

endpackage

// File: rtl/mac_unit.sv
// Two-stage multiply-accumulate: stage 1 registers the product, stage 2 adds it into the accumulator.
module mac_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 19
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_acc,
  input  logic                  en,
  input  logic                  sign,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  acc
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int EXT_W  = (ACC_WIDTH > PROD_W) ? ACC_WIDTH : PROD_W;

  logic [PROD_W-1:0] a_x, b_x, prod_d, prod_q;
  logic [EXT_W-1:0]  prod_ext;
  logic              prod_vld;

  // Extending both operands to the product width makes one unsigned multiplier
  // give the correct low bits for either signedness.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    a_x      = sign ? {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a} : {{DATA_WIDTH{1'b0}}, a};
    b_x      = sign ? {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b} : {{DATA_WIDTH{1'b0}}, b};
    prod_d   = a_x * b_x;
    prod_ext = sign ? EXT_W'($signed(prod_q)) : EXT_W'(prod_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      prod_q   <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
    end else if (clr_acc) begin
      prod_vld <= 1'b0;
      acc      <= '0;
    end else begin
      prod_vld <= en;
      if (en) prod_q <= prod_d;
      if (prod_vld) acc <= acc + prod_ext[ACC_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mat_vec_mult_engine.sv
// ROWS x COLS matrix-vector multiplier fed from per-row A FIFOs and one B FIFO,
// with start/done handshake, signed/unsigned mode and error flags.
module mat_vec_mult_engine
  import mvm_pkg::*;
#(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = default_acc_width(DATA_WIDTH, COLS)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clr,
  input  logic                                a_wren,
  input  logic [ROWS-1:0][DATA_WIDTH-1:0]     a_in,
  input  logic                                b_wren,
  input  logic [DATA_WIDTH-1:0]               b_in,
  input  logic                                sign_mode,
  input  logic                                start,
  output logic                                ready,
  output logic                                busy,
  output logic                                done,
  output logic                                start_err,
  output logic                                wr_err,
  output logic [ROWS-1:0][ACC_WIDTH-1:0]      out
);

  localparam int CW = cnt_width(COLS);
  localparam int PW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CW-1:0] FULL = CW'(COLS);
  localparam logic [PW-1:0] LAST = PW'(COLS - 1);

  state_t state;

  logic [DATA_WIDTH-1:0] a_mem [ROWS][COLS];
  logic [DATA_WIDTH-1:0] b_mem [COLS];

  logic [CW-1:0] a_cnt, b_cnt;
  logic [PW-1:0] rd_ptr;
  logic          flush_cnt;
  logic          sign_q;

  logic idle_or_done, a_full, b_full, start_ok;
  logic a_wr_ok, b_wr_ok, a_wr_bad, b_wr_bad;
  logic mac_en, clr_acc;
  logic [ROWS-1:0][ACC_WIDTH-1:0] acc;

  assign idle_or_done = (state == IDLE) || (state == DONE);
  assign busy         = !idle_or_done;
  assign a_full       = (a_cnt == FULL);
  assign b_full       = (b_cnt == FULL);
  assign ready        = idle_or_done && a_full && b_full;
  assign start_ok     = start && ready && !clr;
  assign a_wr_ok      = a_wren && !clr && idle_or_done && !a_full;
  assign b_wr_ok      = b_wren && !clr && idle_or_done && !b_full;
  assign a_wr_bad     = a_wren && !clr && !(idle_or_done && !a_full);
  assign b_wr_bad     = b_wren && !clr && !(idle_or_done && !b_full);
  assign mac_en       = (state == RUN);
  assign clr_acc      = clr || start_ok;

  // FIFOs always drain completely during a run, so the fill count doubles as write pointer.
  always_ff @(posedge clk) begin
    // NOTE: FIFO storage has no reset; the counts alone decide which entries are valid.
    if (a_wr_ok) begin
      for (int r = 0; r < ROWS; r++) a_mem[r][a_cnt[PW-1:0]] <= a_in[r];
    end
    if (b_wr_ok) b_mem[b_cnt[PW-1:0]] <= b_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_cnt     <= '0;
      b_cnt     <= '0;
      rd_ptr    <= '0;
      flush_cnt <= 1'b0;
      sign_q    <= 1'b0;
      done      <= 1'b0;
      start_err <= 1'b0;
      wr_err    <= 1'b0;
      out       <= '0;
    end else begin
      start_err <= start && !clr && idle_or_done && !(a_full && b_full);
      if (clr) begin
        state     <= IDLE;
        a_cnt     <= '0;
        b_cnt     <= '0;
        rd_ptr    <= '0;
        flush_cnt <= 1'b0;
        done      <= 1'b0;
        wr_err    <= 1'b0;
        out       <= '0;
      end else begin
        if (a_wr_bad || b_wr_bad) wr_err <= 1'b1;

        if (a_wr_ok)     a_cnt <= a_cnt + 1'b1;
        else if (mac_en) a_cnt <= a_cnt - 1'b1;
        if (b_wr_ok)     b_cnt <= b_cnt + 1'b1;
        else if (mac_en) b_cnt <= b_cnt - 1'b1;

        case (state)
          IDLE, DONE: begin
            if (start_ok) begin
              state  <= RUN;
              done   <= 1'b0;
              sign_q <= sign_mode;
              rd_ptr <= '0;
            end
          end
          RUN: begin
            rd_ptr <= rd_ptr + 1'b1;
            if (rd_ptr == LAST) begin
              state     <= FLUSH;
              rd_ptr    <= '0;
              flush_cnt <= 1'b0;
            end
          end
          FLUSH: begin
            // Two cycles let the last product pass through both MAC stages.
            flush_cnt <= 1'b1;
            if (flush_cnt) begin
              state <= DONE;
              done  <= 1'b1;
              out   <= acc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_mac
    mac_unit #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
      .clk     (clk),
      .rst     (rst),
      .clr_acc (clr_acc),
      .en      (mac_en),
      .sign    (sign_q),
      .a       (a_mem[r][rd_ptr]),
      .b       (b_mem[rd_ptr]),
      .acc     (acc[r])
    );
  end

endmodule

// File: tb/tb_mat_vec_mult_engine.sv
// Directed bench for mat_vec_mult_engine with hand-computed expected results.
module tb_mat_vec_mult_engine;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int DW   = 8;
  localparam int AW   = 19;

  logic                      clk, rst, clr;
  logic                      a_wren, b_wren, sign_mode, start;
  logic [ROWS-1:0][DW-1:0]   a_in;
  logic [DW-1:0]             b_in;
  logic                      ready, busy, done, start_err, wr_err;
  logic [ROWS-1:0][AW-1:0]   out;

  int total = 0;
  int bad   = 0;
  int lat;

  mat_vec_mult_engine #(
    .ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ACC_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .a_wren(a_wren), .a_in(a_in), .b_wren(b_wren), .b_in(b_in),
    .sign_mode(sign_mode), .start(start),
    .ready(ready), .busy(busy), .done(done),
    .start_err(start_err), .wr_err(wr_err), .out(out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [DW-1:0] v);
    for (int r = 0; r < ROWS; r++) a_in[r] = v;
    a_wren = 1'b1;
    tick();
    a_wren = 1'b0;
  endtask

  task automatic push_a_ramp();
    for (int r = 0; r < ROWS; r++) a_in[r] = DW'(r + 1);
    a_wren = 1'b1;
    tick();
    a_wren = 1'b0;
  endtask

  task automatic push_b(input logic [DW-1:0] v);
    b_in   = v;
    b_wren = 1'b1;
    tick();
    b_wren = 1'b0;
  endtask

  task automatic load_const(input logic [DW-1:0] av, input logic [DW-1:0] bv, input int n_a);
    for (int i = 0; i < n_a; i++) push_a(av);
    for (int i = 0; i < COLS; i++) push_b(bv);
  endtask

  // sign_mode is flipped right after the start edge to show it was latched.
  task automatic fire_start();
    start = 1'b1;
    tick();
    start     = 1'b0;
    sign_mode = ~sign_mode;
  endtask

  task automatic wait_done(input int elapsed, output int latency);
    latency = -1;
    for (int i = elapsed + 1; i <= 30; i++) begin
      tick();
      if (done) begin
        latency = i;
        break;
      end
    end
  endtask

  task automatic check_outs(input string tag, input logic [63:0] base, input logic [63:0] step);
    for (int r = 0; r < ROWS; r++)
      check($sformatf("%s_r%0d", tag, r), 64'(out[r]), base + step * 64'(r));
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clk = 0; rst = 1; clr = 0; a_wren = 0; b_wren = 0;
    a_in = '0; b_in = '0; sign_mode = 0; start = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    check("rst_ready", 64'(ready), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_start_err", 64'(start_err), 0);
    check("rst_wr_err", 64'(wr_err), 0);
    check("rst_out0", 64'(out[0]), 0);

    // All A=2, b=2 unsigned: 8 * 4 = 32
    load_const(8'd2, 8'd2, COLS);
    check("const_ready", 64'(ready), 1);
    fire_start();
    check("const_busy", 64'(busy), 1);
    check("const_done_low", 64'(done), 0);
    wait_done(0, lat);
    check("const_latency", 64'(lat), 10);
    check_outs("const", 64'd32, 64'd0);
    check("const_drained", 64'(ready), 0);
    check("const_idle", 64'(busy), 0);

    // Overlap next load with readback; A[r][c]=r+1, b[c]=c+1 -> 36*(r+1)
    sign_mode = 0;
    for (int c = 0; c < COLS; c++) push_a_ramp();
    for (int c = 0; c < COLS; c++) push_b(DW'(c + 1));
    check("overlap_done_held", 64'(done), 1);
    check("overlap_out_held", 64'(out[3]), 32);
    check("overlap_ready", 64'(ready), 1);
    fire_start();
    wait_done(0, lat);
    check("ramp_latency", 64'(lat), 10);
    check_outs("ramp", 64'd36, 64'd36);

    // A=-1, b=3 signed -> -24
    sign_mode = 1;
    load_const(8'hFF, 8'd3, COLS);
    fire_start();
    wait_done(0, lat);
    check("signed_latency", 64'(lat), 10);
    check_outs("signed", 64'h7FFE8, 64'd0);

    // Same data unsigned -> 255*3*8 = 6120
    sign_mode = 0;
    load_const(8'hFF, 8'd3, COLS);
    fire_start();
    wait_done(0, lat);
    check_outs("unsigned", 64'h017E8, 64'd0);

    // start with only 5 A columns loaded
    pulse_clr();
    check("clr_done", 64'(done), 0);
    check("clr_out", 64'(out[5]), 0);
    load_const(8'd2, 8'd2, 5);
    check("partial_ready", 64'(ready), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_err_pulse", 64'(start_err), 1);
    check("start_err_busy", 64'(busy), 0);
    tick();
    check("start_err_clear", 64'(start_err), 0);
    check("start_err_still_idle", 64'(busy), 0);

    // Complete the load, then overflow with a 9th A write
    for (int i = 0; i < 3; i++) push_a(8'd2);
    check("fill_ready", 64'(ready), 1);
    check("fill_wr_err", 64'(wr_err), 0);
    push_a(8'hAA);
    check("overflow_wr_err", 64'(wr_err), 1);
    fire_start();
    wait_done(0, lat);
    check("overflow_latency", 64'(lat), 10);
    check_outs("overflow", 64'd32, 64'd0);
    check("wr_err_sticky", 64'(wr_err), 1);
    pulse_clr();
    check("clr_wr_err", 64'(wr_err), 0);

    // Write during RUN is dropped and flagged
    load_const(8'd2, 8'd2, COLS);
    fire_start();
    push_a(8'h55);
    check("run_write_wr_err", 64'(wr_err), 1);
    wait_done(1, lat);
    check("run_write_latency", 64'(lat), 10);
    check_outs("run_write", 64'd32, 64'd0);
    pulse_clr();

    // clr three cycles into RUN abandons the run
    load_const(8'd2, 8'd2, COLS);
    fire_start();
    repeat (3) tick();
    pulse_clr();
    wait_done(4, lat);
    check("clr_run_no_done", 64'(lat), -64'sd1);
    check("clr_run_out0", 64'(out[0]), 0);
    check("clr_run_out7", 64'(out[7]), 0);
    check("clr_run_ready", 64'(ready), 0);
    load_const(8'd2, 8'd2, COLS);
    fire_start();
    wait_done(0, lat);
    check("after_clr_latency", 64'(lat), 10);
    check_outs("after_clr", 64'd32, 64'd0);

    // Same with asynchronous rst mid-run
    load_const(8'd2, 8'd2, COLS);
    fire_start();
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    check("rst_run_out_async", 64'(out[1]), 0);
    check("rst_run_busy_async", 64'(busy), 0);
    tick();
    rst = 1'b0;
    wait_done(5, lat);
    check("rst_run_no_done", 64'(lat), -64'sd1);
    check("rst_run_out0", 64'(out[0]), 0);
    check("rst_run_ready", 64'(ready), 0);
    load_const(8'd2, 8'd2, COLS);
    fire_start();
    wait_done(0, lat);
    check("after_rst_latency", 64'(lat), 10);
    check_outs("after_rst", 64'd32, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mat_vec_mult_engine.md
Name: mat_vec_mult_engine

Overview:
- Parametrised successor to the fixed 8x8 matrix-vector multiplier: computes out[r] = sum over c of A[r][c]*b[c] for a ROWS x COLS matrix.
- Per-row A FIFOs and one B FIFO are loaded by the host. A start/done handshake, selectable signed/unsigned arithmetic and error flagging are added.
- Sits between the host load path and result readback, driven by the same testbench-style loaders (a_wren/b_wren).

Parameters:
ROWS, 8, number of matrix rows = number of A FIFOs = number of outputs
COLS, 8, vector length = depth of every FIFO = MAC iterations
DATA_WIDTH, 8, width of each A/b element
ACC_WIDTH, 2*DATA_WIDTH+$clog2(COLS), accumulator/output width; results wrap modulo 2^ACC_WIDTH if set smaller

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  asynchronous, active-high reset
clr  input  1  synchronous clear: flush FIFOs, zero accumulators, return to IDLE
a_wren  input  1  write one column element into every row FIFO
a_in  input  [ROWS] x DATA_WIDTH  a_in[r] = A[r][c] for the current column c
b_wren  input  1  write one b element
b_in  input  DATA_WIDTH  b[c]
sign_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled on accepted start
start  input  1  single-cycle request to compute
ready  output  1  IDLE/DONE and every A FIFO and the B FIFO hold COLS entries
busy  output  1  state is RUN or FLUSH
done  output  1  results valid; held until next accepted start, clr or rst
start_err  output  1  one-cycle pulse: start seen while not ready
wr_err  output  1  sticky: write to a full FIFO or write during RUN/FLUSH; cleared by clr/rst
out  output  [ROWS] x ACC_WIDTH  per-row dot products

Behaviour:
- Reset (async, rst=1): all FIFOs empty; accumulators, out, done, busy, start_err and wr_err are 0; state IDLE.
- States:
  - IDLE -> RUN on start && ready.
  - RUN -> FLUSH after COLS pop cycles.
  - FLUSH -> DONE after 2 cycles.
  - DONE -> RUN on start && ready.
  - Any state -> IDLE on clr.
- Writes:
  - Accepted in IDLE and DONE only. A FIFOs share one write count.
  - A write when the count equals COLS is dropped and sets wr_err; stored data is unchanged.
  - A write in RUN/FLUSH is dropped and sets wr_err.
- Accepted start (edge T):
  - Accumulators zeroed.
  - done deasserts at T.
  - sign_mode is latched.
- RUN (edges T+1..T+COLS): each cycle pops one entry from every A FIFO and from the B FIFO in lockstep.
- MAC pipeline: stage 1 registers the product (2*DATA_WIDTH wide, sign-extended when signed); stage 2 adds the product into the accumulator (ACC_WIDTH).
- Latency: done rises at edge T+COLS+2 and out is final at that edge. out changes only at that edge; between runs it holds the last result.
- start when not ready: ignored; start_err pulses for 1 cycle; state unchanged.
- start during RUN/FLUSH: ignored, no error.
- clr has priority over start and wren in the same cycle. Writes in that cycle are dropped without setting wr_err.
- clr or rst mid-run: run abandoned, done stays 0, out forced to 0.
- Next-run loading during DONE is allowed (overlap load with readback).

Decomposition:
- Package mvm_pkg: state enum (IDLE, RUN, FLUSH, DONE); localparam CNT_W=$clog2(COLS+1); function computing default ACC_WIDTH.
- Sub-module mac_unit (DATA_WIDTH, ACC_WIDTH): 2-stage signed/unsigned multiply-accumulate with clr_acc and en inputs, instantiated ROWS times.
- FIFOs are simple counter-addressed arrays, inline or an existing fifo module of depth COLS.

Test Plan:
- Defaults, all A=2, b=2, sign_mode=0, start -> ready=1 before start; done rises 10 cycles after the start edge; every out[r]=32.
- A[r][c]=r+1, b[c]=c+1, unsigned -> out[r]=36*(r+1), i.e. 36, 72, ..., 288.
- All A=8'hFF, b=3, over 8 columns:
  - sign_mode=1 -> out = -24 = 19'h7FFE8.
  - repeat with sign_mode=0 -> out = 6120 = 19'h017E8.
- start after only 5 A loads -> start_err pulses once, busy stays 0, state IDLE.
- 9th a_wren after 8 loads -> wr_err=1, results unchanged (still 32); a_wren during RUN -> wr_err=1. clr clears wr_err.
- clr asserted 3 cycles into RUN -> done never rises, out=0, ready=0. Reload and start -> correct 32 results. Repeat with rst instead of clr -> same outcome.
